// File: rtl/iobus_uart_pkg.sv
// Register offsets, STATUS bit positions and TX state encoding shared by the IOBUS UART transmitter.
package iobus_uart_pkg;

    localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS = 32'h0000_0004;
    localparam logic [31:0] CTRL_OFS   = 32'h0000_0008;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;
    localparam int STAT_INTR  = 4;
    localparam int STAT_COUNT = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

endpackage

// File: rtl/iobus_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read; a push while full succeeds only alongside a pop.
module iobus_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         popData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] memArray [DEPTH];
    logic [AW-1:0]    wrPtrReg;
    logic [AW-1:0]    rdPtrReg;
    logic [AW:0]      countReg;
    logic             doPush;
    logic             doPop;

    assign empty   = (countReg == '0);
    assign full    = (countReg == (AW+1)'(DEPTH));
    assign count   = countReg;
    assign popData = memArray[rdPtrReg];
    assign doPop   = pop && !empty;
    assign doPush  = push && (!full || doPop);

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge CLK) begin
        if (doPush) begin
            memArray[wrPtrReg] <= pushData;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (doPush) begin
                wrPtrReg <= wrPtrReg + 1'b1;
            end
            if (doPop) begin
                rdPtrReg <= rdPtrReg + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   countReg <= countReg + 1'b1;
                2'b01:   countReg <= countReg - 1'b1;
                default: countReg <= countReg;
            endcase
        end
    end

endmodule

// File: rtl/iobus_uart_tx.sv
// IOBUS-mapped 8N1 UART transmitter with TX FIFO and STATUS register.
// Define IOBUS_UART_INTR_EN to add the CTRL interrupt enable and the TX_INTR output.
module iobus_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h1100_0000,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        TX
`ifdef IOBUS_UART_INTR_EN
    ,
    output logic        TX_INTR
`endif
);
    import iobus_uart_pkg::*;

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int NW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    uart_tx_state_t stateReg;
    logic [CW-1:0]  baudCntReg;
    logic [2:0]     bitIdxReg;
    logic [7:0]     shiftReg;
    logic           txReg;
    logic           ovfReg;

    logic           selTxData;
    logic           selStatus;
    logic           selCtrl;
    logic           pushReq;
    logic           baudLast;
    logic           fifoPop;
    logic           fifoFull;
    logic           fifoEmpty;
    logic [7:0]     fifoData;
    logic [NW-1:0]  fifoCount;
    logic           intrBit;
    logic [31:0]    ctrlRead;
    logic [31:0]    statusWord;
    logic [31:0]    readData;
    logic           unusedBits;

    assign selTxData  = (IOBUS_ADDR == BASE_ADDR + TXDATA_OFS);
    assign selStatus  = (IOBUS_ADDR == BASE_ADDR + STATUS_OFS);
    assign selCtrl    = (IOBUS_ADDR == BASE_ADDR + CTRL_OFS);
    assign pushReq    = IOBUS_WR && selTxData;
    assign baudLast   = (baudCntReg == BAUD_LAST);
    assign unusedBits = ^IOBUS_OUT[31:8];

    // Pop on leaving IDLE or at the last cycle of a stop bit, so frames chain with no gap.
    assign fifoPop = !fifoEmpty && ((stateReg == IDLE) || (stateReg == STOP && baudLast));

    iobus_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) txFifo (
        .CLK      (CLK),
        .RESET    (RESET),
        .push     (pushReq),
        .pushData (IOBUS_OUT[7:0]),
        .pop      (fifoPop),
        .popData  (fifoData),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stateReg   <= IDLE;
            baudCntReg <= '0;
            bitIdxReg  <= '0;
            shiftReg   <= '0;
            txReg      <= 1'b1;
        end else begin
            case (stateReg)
                IDLE: begin
                    txReg      <= 1'b1;
                    baudCntReg <= '0;
                    if (fifoPop) begin
                        shiftReg <= fifoData;
                        txReg    <= 1'b0;
                        stateReg <= START;
                    end
                end
                START: begin
                    if (baudLast) begin
                        baudCntReg <= '0;
                        bitIdxReg  <= '0;
                        txReg      <= shiftReg[0];
                        stateReg   <= DATA;
                    end else begin
                        baudCntReg <= baudCntReg + 1'b1;
                    end
                end
                DATA: begin
                    if (baudLast) begin
                        baudCntReg <= '0;
                        if (bitIdxReg == 3'd7) begin
                            txReg    <= 1'b1;
                            stateReg <= STOP;
                        end else begin
                            bitIdxReg <= bitIdxReg + 1'b1;
                            shiftReg  <= {1'b0, shiftReg[7:1]};
                            txReg     <= shiftReg[1];
                        end
                    end else begin
                        baudCntReg <= baudCntReg + 1'b1;
                    end
                end
                STOP: begin
                    if (baudLast) begin
                        baudCntReg <= '0;
                        if (fifoPop) begin
                            shiftReg <= fifoData;
                            txReg    <= 1'b0;
                            stateReg <= START;
                        end else begin
                            stateReg <= IDLE;
                        end
                    end else begin
                        baudCntReg <= baudCntReg + 1'b1;
                    end
                end
                default: begin
                    txReg    <= 1'b1;
                    stateReg <= IDLE;
                end
            endcase
        end
    end

    // A dropped push and a clear cannot coincide: they target different addresses.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ovfReg <= 1'b0;
        end else if (IOBUS_WR && selStatus) begin
            ovfReg <= 1'b0;
        end else if (pushReq && fifoFull && !fifoPop) begin
            ovfReg <= 1'b1;
        end
    end

`ifdef IOBUS_UART_INTR_EN
    logic ctrlEnReg;
    logic txIntrReg;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ctrlEnReg <= 1'b0;
            txIntrReg <= 1'b0;
        end else begin
            if (IOBUS_WR && selCtrl) begin
                ctrlEnReg <= IOBUS_OUT[0];
            end
            txIntrReg <= ctrlEnReg && fifoEmpty && (stateReg == IDLE);
        end
    end

    assign TX_INTR  = txIntrReg;
    assign intrBit  = txIntrReg;
    assign ctrlRead = {31'b0, ctrlEnReg};
`else
    assign intrBit  = 1'b0;
    assign ctrlRead = 32'b0;
`endif

    always_comb begin
        statusWord                   = '0;
        statusWord[STAT_FULL]        = fifoFull;
        statusWord[STAT_EMPTY]       = fifoEmpty;
        statusWord[STAT_BUSY]        = (stateReg != IDLE);
        statusWord[STAT_OVF]         = ovfReg;
        statusWord[STAT_INTR]        = intrBit;
        statusWord[STAT_COUNT +: NW] = fifoCount;
    end

    always_comb begin
        readData = '0;
        if (selStatus) begin
            readData = statusWord;
        end else if (selCtrl) begin
            readData = ctrlRead;
        end
    end

    assign IOBUS_IN = readData;
    assign TX       = txReg;

endmodule

// File: tb/tb_iobus_uart_tx.sv
// Self-checking bench for iobus_uart_tx: directed plan followed by random IOBUS traffic against a frame-level model.
module tb_iobus_uart_tx;

    localparam int          C    = 4;
    localparam int          D    = 4;
    localparam logic [31:0] BASE = 32'h1100_0000;
    localparam logic [31:0] STAT = BASE + 32'h4;
    localparam logic [31:0] CTRL = BASE + 32'h8;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_IN;
    logic        TX;
`ifdef IOBUS_UART_INTR_EN
    logic        TX_INTR;
`endif

    iobus_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .IOBUS_IN   (IOBUS_IN)
`ifdef IOBUS_UART_INTR_EN
        ,
        .TX_INTR    (TX_INTR)
`endif
        ,
        .TX         (TX)
    );

    always #5 CLK = ~CLK;

    int nComp = 0;
    int nFail = 0;

    // Model: pending bytes, the frame on the wire (start edge + byte), sticky flags.
    logic [7:0] mq[$];
    logic [7:0] mCur;
    bit         mBusy;
    bit         mOvf;
    bit         mEn;
    bit         mIntr;
    int         mStart;
    int         edgeN = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nComp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, edgeN);
        end
    endtask

    task automatic modelEdge(input bit rst, input bit wr, input logic [31:0] a, input logic [31:0] d);
        int  sz;
        bit  popNow;
        edgeN++;
        if (rst) begin
            mq.delete();
            mBusy = 0;
            mOvf  = 0;
            mEn   = 0;
            mIntr = 0;
            return;
        end
        mIntr  = mEn && (mq.size() == 0) && !mBusy;
        sz     = mq.size();
        popNow = 0;
        if (mBusy && (edgeN == mStart + 10 * C)) mBusy = 0;
        if (!mBusy && sz > 0) begin
            popNow = 1;
            mCur   = mq.pop_front();
            mStart = edgeN;
            mBusy  = 1;
        end
        if (wr && a == BASE) begin
            if (sz < D || popNow) mq.push_back(d[7:0]);
            else mOvf = 1;
        end
        if (wr && a == STAT) mOvf = 0;
`ifdef IOBUS_UART_INTR_EN
        if (wr && a == CTRL) mEn = d[0];
`endif
    endtask

    function automatic logic expTx();
        int bp;
        if (!mBusy) return 1'b1;
        bp = (edgeN - mStart) / C;
        if (bp == 0) return 1'b0;
        if (bp >= 9) return 1'b1;
        return mCur[bp-1];
    endfunction

    function automatic logic [31:0] expStatus();
        logic [31:0] s;
        logic [6:0]  cnt;
        s      = '0;
        cnt    = 7'(mq.size());
        s[0]   = (mq.size() == D);
        s[1]   = (mq.size() == 0);
        s[2]   = mBusy;
        s[3]   = mOvf;
`ifdef IOBUS_UART_INTR_EN
        s[4]   = mIntr;
`endif
        s[14:8] = cnt;
        return s;
    endfunction

    function automatic logic [31:0] expRead(input logic [31:0] a);
        if (a == STAT) return expStatus();
`ifdef IOBUS_UART_INTR_EN
        if (a == CTRL) return {31'b0, mEn};
`endif
        return 32'h0;
    endfunction

    // One clock: drive a write/reset, then check TX and a read of address ra.
    task automatic step(input bit rst, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] ra);
        RESET      = rst;
        IOBUS_WR   = wr;
        IOBUS_ADDR = a;
        IOBUS_OUT  = d;
        @(posedge CLK);
        modelEdge(rst, wr, a, d);
        #1;
        chk("tx", {31'b0, TX}, {31'b0, expTx()});
        RESET      = 1'b0;
        IOBUS_WR   = 1'b0;
        IOBUS_ADDR = ra;
        #1;
        chk("read", IOBUS_IN, expRead(ra));
`ifdef IOBUS_UART_INTR_EN
        chk("txIntr", {31'b0, TX_INTR}, {31'b0, mIntr});
`endif
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, 32'h0, STAT);
    endtask

    task automatic wrByte(input logic [7:0] b);
        step(0, 1, BASE, {24'h0, b}, STAT);
    endtask

    initial begin
        RESET      = 1'b1;
        IOBUS_WR   = 1'b0;
        IOBUS_ADDR = 32'h0;
        IOBUS_OUT  = 32'h0;

        step(1, 0, 32'h0, 32'h0, STAT);
        step(1, 0, 32'h0, 32'h0, STAT);
        chk("rstStatus", IOBUS_IN, 32'h0000_0002);
        chk("rstTx", {31'b0, TX}, 32'h1);

        wrByte(8'hA5);
        idleCycles(45);
        chk("a5Done", IOBUS_IN, 32'h0000_0002);

        wrByte(8'h01);
        wrByte(8'h02);
        idleCycles(85);

        for (int i = 0; i < 6; i++) wrByte(8'h10 + 8'(i));
        chk("ovfStatus", IOBUS_IN, 32'h0000_040D);
        step(0, 1, STAT, 32'h0, STAT);
        chk("ovfClear", IOBUS_IN, 32'h0000_0405);
        idleCycles(5 * 10 * C + 10);

        wrByte(8'h3C);
        idleCycles(18);
        step(1, 0, 32'h0, 32'h0, STAT);
        chk("midRstTx", {31'b0, TX}, 32'h1);
        chk("midRstStatus", IOBUS_IN, 32'h0000_0002);
        idleCycles(60);

        step(0, 0, 32'h0, 32'h0, BASE);
        step(0, 0, 32'h0, 32'h0, CTRL);
        step(0, 0, 32'h0, 32'h0, BASE + 32'hC);
        step(0, 1, BASE + 32'h1, 32'h77, STAT);
        chk("unmappedWr", IOBUS_IN, 32'h0000_0002);

`ifdef IOBUS_UART_INTR_EN
        step(0, 1, CTRL, 32'h1, CTRL);
        chk("ctrlRd", IOBUS_IN, 32'h1);
        idleCycles(1);
        chk("intrOn", {31'b0, TX_INTR}, 32'h1);
        wrByte(8'h55);
        idleCycles(1);
        chk("intrBusy", {31'b0, TX_INTR}, 32'h0);
        idleCycles(40);
        chk("intrEnd", {31'b0, TX_INTR}, 32'h0);
        idleCycles(1);
        chk("intrBack", {31'b0, TX_INTR}, 32'h1);
`endif

        for (int i = 0; i < 3000; i++) begin
            int          r;
            logic [31:0] ra;
            logic [31:0] rd;
            r  = int'($urandom_range(0, 199));
            rd = $urandom;
            case ($urandom_range(0, 4))
                0:       ra = BASE;
                1:       ra = CTRL;
                2:       ra = BASE + 32'hC;
                default: ra = STAT;
            endcase
            if (r < 40)       step(0, 1, BASE, rd, ra);
            else if (r < 46)  step(0, 1, STAT, rd, ra);
            else if (r < 52)  step(0, 1, CTRL, rd, ra);
            else if (r < 56)  step(0, 1, BASE + 32'h2, rd, ra);
            else if (r < 57)  step(1, 0, 32'h0, 32'h0, ra);
            else              step(0, 0, 32'h0, 32'h0, ra);
        end
        idleCycles(10 * C * (D + 1) + 5);
        chk("drained", IOBUS_IN & 32'hFFFF_FFEF, mOvf ? 32'h0000_000A : 32'h0000_0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
        $finish;
    end

endmodule
